// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, ALU functions, condition codes, status codes and E-stage types.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_XOR = 2'b11;

   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_HLT = 3'd2;
   localparam logic [2:0] S_ADR = 3'd3;
   localparam logic [2:0] S_INS = 3'd4;

   localparam logic [3:0] RNONE = 4'hF;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } ccFlags_t;

   // Control half of the E register; the W-wide operands live beside it in the stage.
   typedef struct packed {
      logic [2:0] stat;
      logic [3:0] icode;
      logic [3:0] ifun;
      logic [3:0] dstE;
      logic [3:0] dstM;
      logic [3:0] srcA;
      logic [3:0] srcB;
   } eCtl_t;

   localparam ccFlags_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

   localparam eCtl_t E_CTL_BUBBLE = '{stat: S_AOK, icode: I_NOP, ifun: 4'h0,
                                      dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};

   function automatic logic isException(input logic [2:0] stat);
      return (stat == S_ADR) || (stat == S_INS) || (stat == S_HLT);
   endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-execute bundle: D-side inputs, downstream status, ALU flags and all E-stage outputs.
interface execute_stage_if #(parameter int W = 64);
   logic          E_stall;
   logic          E_bubble;
   logic [2:0]    d_stat;
   logic [3:0]    d_icode;
   logic [3:0]    d_ifun;
   logic [W-1:0]  d_valC;
   logic [W-1:0]  d_valA;
   logic [W-1:0]  d_valB;
   logic [3:0]    d_dstE;
   logic [3:0]    d_dstM;
   logic [3:0]    d_srcA;
   logic [3:0]    d_srcB;
   logic [2:0]    m_stat;
   logic [2:0]    W_stat;
   logic          alu_zf;
   logic          alu_sf;
   logic          alu_of;
   logic [1:0]    aluFun;
   logic [W-1:0]  aluA;
   logic [W-1:0]  aluB;
   logic          e_Cnd;
   logic [3:0]    e_dstE;
   logic [2:0]    E_stat;
   logic [3:0]    E_icode;
   logic [3:0]    E_ifun;
   logic [W-1:0]  E_valA;
   logic [3:0]    E_dstM;
   logic [3:0]    E_srcA;
   logic [3:0]    E_srcB;
   logic          cc_zf;
   logic          cc_sf;
   logic          cc_of;

   modport master (
      output E_stall, E_bubble, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
             d_dstE, d_dstM, d_srcA, d_srcB, m_stat, W_stat, alu_zf, alu_sf, alu_of,
      input  aluFun, aluA, aluB, e_Cnd, e_dstE, E_stat, E_icode, E_ifun, E_valA,
             E_dstM, E_srcA, E_srcB, cc_zf, cc_sf, cc_of
   );

   modport slave (
      input  E_stall, E_bubble, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
             d_dstE, d_dstM, d_srcA, d_srcB, m_stat, W_stat, alu_zf, alu_sf, alu_of,
      output aluFun, aluA, aluB, e_Cnd, e_dstE, E_stat, E_icode, E_ifun, E_valA,
             E_dstM, E_srcA, E_srcB, cc_zf, cc_sf, cc_of
   );
endinterface

// File: rtl/cond_eval.sv
// Pure combinational jXX/cmovXX condition: ifun plus condition codes to Cnd.
// Shared with the fetch predictor, so it carries no state and no clock.
module cond_eval
   import y86_pkg::*;
(
   input  logic [3:0] ifun,
   input  ccFlags_t   cc,
   output logic       cnd
);
   logic less;

   always_comb begin
      less = cc.sf ^ cc.of;
      cnd  = 1'b0;
      case (ifun)
         C_YES:   cnd = 1'b1;
         C_LE:    cnd = less | cc.zf;
         C_L:     cnd = less;
         C_E:     cnd = cc.zf;
         C_NE:    cnd = ~cc.zf;
         C_GE:    cnd = ~less;
         C_G:     cnd = ~less & ~cc.zf;
         default: cnd = 1'b0;
      endcase
   end
endmodule

// File: rtl/execute_stage.sv
// Y86-64 E stage: D->E pipeline register with stall/bubble, ALU operand select, CC register and Cnd.
// One cycle d_* to E_*; operands, e_Cnd and e_dstE are combinational from registered state.
module execute_stage
   import y86_pkg::*;
#(
   parameter int W          = 64,
   parameter int STACK_STEP = 8
)(
   input logic clk,
   input logic rst,
   execute_stage_if.slave eif
);
   localparam logic [W-1:0] STEP_W = W'(STACK_STEP);

   eCtl_t         eCtl;
   logic [W-1:0]  eValC;
   logic [W-1:0]  eValA;
   logic [W-1:0]  eValB;
   ccFlags_t      ccQ;
   logic          setCc;
   logic          cnd;

   // Stall beats bubble: a stalled slot must keep its instruction even if a bubble is also requested.
   always_ff @(posedge clk) begin
      if (rst) begin
         eCtl  <= E_CTL_BUBBLE;
         eValC <= '0;
         eValA <= '0;
         eValB <= '0;
      end else if (!eif.E_stall) begin
         if (eif.E_bubble) begin
            eCtl  <= E_CTL_BUBBLE;
            eValC <= '0;
            eValA <= '0;
            eValB <= '0;
         end else begin
            eCtl  <= '{stat: eif.d_stat, icode: eif.d_icode, ifun: eif.d_ifun,
                       dstE: eif.d_dstE, dstM: eif.d_dstM,
                       srcA: eif.d_srcA, srcB: eif.d_srcB};
            eValC <= eif.d_valC;
            eValA <= eif.d_valA;
            eValB <= eif.d_valB;
         end
      end
   end

   // A faulting instruction downstream must not see its younger OPQ's flags.
   assign setCc = (eCtl.icode == I_OPQ) && !isException(eif.m_stat) && !isException(eif.W_stat);

   always_ff @(posedge clk) begin
      if (rst) begin
         ccQ <= CC_RESET;
      end else if (setCc) begin
         ccQ <= '{zf: eif.alu_zf, sf: eif.alu_sf, of: eif.alu_of};
      end
   end

   always_comb begin
      eif.aluA = '0;
      case (eCtl.icode)
         I_RRMOVQ, I_OPQ:             eif.aluA = eValA;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: eif.aluA = eValC;
         I_CALL, I_PUSHQ:             eif.aluA = '0 - STEP_W;
         I_RET, I_POPQ:               eif.aluA = STEP_W;
         default:                     eif.aluA = '0;
      endcase
   end

   always_comb begin
      eif.aluB = '0;
      case (eCtl.icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: eif.aluB = eValB;
         default:                                                  eif.aluB = '0;
      endcase
   end

   assign eif.aluFun = (eCtl.icode == I_OPQ) ? eCtl.ifun[1:0] : ALU_ADD;

   cond_eval u_condEval (
      .ifun (eCtl.ifun),
      .cc   (ccQ),
      .cnd  (cnd)
   );

   assign eif.e_Cnd  = cnd;
   assign eif.e_dstE = ((eCtl.icode == I_RRMOVQ) && !cnd) ? RNONE : eCtl.dstE;

   assign eif.E_stat  = eCtl.stat;
   assign eif.E_icode = eCtl.icode;
   assign eif.E_ifun  = eCtl.ifun;
   assign eif.E_valA  = eValA;
   assign eif.E_dstM  = eCtl.dstM;
   assign eif.E_srcA  = eCtl.srcA;
   assign eif.E_srcB  = eCtl.srcB;
   assign eif.cc_zf   = ccQ.zf;
   assign eif.cc_sf   = ccQ.sf;
   assign eif.cc_of   = ccQ.of;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios then random traffic against a reference model.
module tb_execute_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   execute_stage_if #(.W(64)) eif ();

   execute_stage #(.W(64), .STACK_STEP(8)) dut (
      .clk (clk),
      .rst (rst),
      .eif (eif)
   );

   // Reference state: what the E slot and the flags hold, as plain variables.
   logic [2:0]  mStat;
   logic [3:0]  mIcode, mIfun, mDstE, mDstM, mSrcA, mSrcB;
   logic [63:0] mValC, mValA, mValB;
   logic        mZf, mSf, mOf;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic refCnd(input logic [3:0] f, input logic z, input logic s, input logic o);
      logic less;
      less = s ^ o;
      case (f)
         4'd0:    return 1'b1;
         4'd1:    return less | z;
         4'd2:    return less;
         4'd3:    return z;
         4'd4:    return !z;
         4'd5:    return !less;
         4'd6:    return !less && !z;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [63:0] refAluA();
      if (mIcode inside {4'h2, 4'h6})             return mValA;
      else if (mIcode inside {4'h3, 4'h4, 4'h5})  return mValC;
      else if (mIcode inside {4'h8, 4'hA})        return 64'hFFFF_FFFF_FFFF_FFF8;
      else if (mIcode inside {4'h9, 4'hB})        return 64'd8;
      return 64'd0;
   endfunction

   function automatic logic [63:0] refAluB();
      if (mIcode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) return mValB;
      return 64'd0;
   endfunction

   function automatic logic badStat(input logic [2:0] s);
      return s inside {3'd2, 3'd3, 3'd4};
   endfunction

   task automatic modelBubble();
      mStat = 3'd1; mIcode = 4'h1; mIfun = 4'h0;
      mValC = '0; mValA = '0; mValB = '0;
      mDstE = 4'hF; mDstM = 4'hF; mSrcA = 4'hF; mSrcB = 4'hF;
   endtask

   // Advance the model by one rising edge using the inputs currently driven.
   task automatic modelEdge();
      if (rst) begin
         modelBubble();
         {mZf, mSf, mOf} = 3'b100;
      end else begin
         if (mIcode == 4'h6 && !badStat(eif.m_stat) && !badStat(eif.W_stat))
            {mZf, mSf, mOf} = {eif.alu_zf, eif.alu_sf, eif.alu_of};
         if (eif.E_stall) begin
         end else if (eif.E_bubble) begin
            modelBubble();
         end else begin
            mStat = eif.d_stat; mIcode = eif.d_icode; mIfun = eif.d_ifun;
            mValC = eif.d_valC; mValA = eif.d_valA; mValB = eif.d_valB;
            mDstE = eif.d_dstE; mDstM = eif.d_dstM; mSrcA = eif.d_srcA; mSrcB = eif.d_srcB;
         end
      end
   endtask

   task automatic checkAll();
      logic c;
      c = refCnd(mIfun, mZf, mSf, mOf);
      chk("E_stat",  64'(eif.E_stat),  64'(mStat));
      chk("E_icode", 64'(eif.E_icode), 64'(mIcode));
      chk("E_ifun",  64'(eif.E_ifun),  64'(mIfun));
      chk("E_valA",  eif.E_valA,       mValA);
      chk("E_dstM",  64'(eif.E_dstM),  64'(mDstM));
      chk("E_srcA",  64'(eif.E_srcA),  64'(mSrcA));
      chk("E_srcB",  64'(eif.E_srcB),  64'(mSrcB));
      chk("cc",      64'({eif.cc_zf, eif.cc_sf, eif.cc_of}), 64'({mZf, mSf, mOf}));
      chk("aluA",    eif.aluA, refAluA());
      chk("aluB",    eif.aluB, refAluB());
      chk("aluFun",  64'(eif.aluFun), (mIcode == 4'h6) ? 64'(mIfun % 4) : 64'd0);
      chk("e_Cnd",   64'(eif.e_Cnd), 64'(c));
      chk("e_dstE",  64'(eif.e_dstE), (mIcode == 4'h2 && !c) ? 64'hF : 64'(mDstE));
   endtask

   task automatic tick();
      modelEdge();
      @(posedge clk);
      #1;
      checkAll();
   endtask

   task automatic setFlags(input logic z, input logic s, input logic o);
      eif.alu_zf = z; eif.alu_sf = s; eif.alu_of = o;
   endtask

   task automatic loadInstr(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                            input logic [63:0] va, input logic [63:0] vb, input logic [3:0] de);
      eif.d_stat = 3'd1; eif.d_icode = ic; eif.d_ifun = fn;
      eif.d_valC = vc; eif.d_valA = va; eif.d_valB = vb;
      eif.d_dstE = de; eif.d_dstM = 4'hF; eif.d_srcA = 4'h2; eif.d_srcB = 4'h3;
   endtask

   initial begin
      modelBubble();
      {mZf, mSf, mOf} = 3'b100;
      eif.E_stall = 1'b0; eif.E_bubble = 1'b0;
      eif.m_stat = 3'd1;  eif.W_stat = 3'd1;
      setFlags(1'b0, 1'b0, 1'b0);
      loadInstr(4'h6, 4'h0, 64'h77, 64'h55, 64'h66, 4'h4);

      // Reset
      rst = 1'b1;
      tick();
      tick();
      chk("rst_icode", 64'(eif.E_icode), 64'd1);
      chk("rst_stat",  64'(eif.E_stat),  64'd1);
      chk("rst_regs",  64'({eif.E_dstM, eif.E_srcA, eif.E_srcB, eif.e_dstE}), 64'hFFFF);
      chk("rst_cc",    64'({eif.cc_zf, eif.cc_sf, eif.cc_of}), 64'b100);
      chk("rst_alu",   eif.aluA | eif.aluB | 64'(eif.aluFun), 64'd0);
      rst = 1'b0;

      // subq 5,5 then je / jne on the resulting ZF
      loadInstr(4'h6, 4'h1, 64'h0, 64'd5, 64'd5, 4'h3);
      tick();
      setFlags(1'b1, 1'b0, 1'b0);
      chk("subq_fun", 64'(eif.aluFun), 64'd1);
      chk("subq_a",   eif.aluA, 64'd5);
      chk("subq_b",   eif.aluB, 64'd5);
      loadInstr(4'h7, 4'h3, 64'h40, 64'h0, 64'h0, 4'hF);
      tick();
      chk("subq_zf", 64'(eif.cc_zf), 64'd1);
      chk("je_cnd",  64'(eif.e_Cnd), 64'd1);
      loadInstr(4'h7, 4'h4, 64'h40, 64'h0, 64'h0, 4'hF);
      tick();
      chk("jne_cnd", 64'(eif.e_Cnd), 64'd0);

      // cmovl taken (SF=1,OF=0) then squashed (SF=OF=1)
      loadInstr(4'h6, 4'h0, 64'h0, 64'd1, 64'd2, 4'h1);
      tick();
      setFlags(1'b0, 1'b1, 1'b0);
      loadInstr(4'h2, 4'h2, 64'h0, 64'h9, 64'h0, 4'h5);
      tick();
      chk("cmovl_cnd",  64'(eif.e_Cnd), 64'd1);
      chk("cmovl_dstE", 64'(eif.e_dstE), 64'd5);
      loadInstr(4'h6, 4'h0, 64'h0, 64'd1, 64'd2, 4'h1);
      tick();
      setFlags(1'b0, 1'b1, 1'b1);
      loadInstr(4'h2, 4'h2, 64'h0, 64'h9, 64'h0, 4'h5);
      tick();
      chk("cmovl_nt_cnd",  64'(eif.e_Cnd), 64'd0);
      chk("cmovl_nt_dstE", 64'(eif.e_dstE), 64'hF);

      // Stack and immediate operands
      loadInstr(4'hA, 4'h0, 64'h0, 64'h3, 64'h100, 4'h4);
      tick();
      chk("push_a", eif.aluA, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("push_b", eif.aluB, 64'h100);
      loadInstr(4'hB, 4'h0, 64'h0, 64'h0, 64'h100, 4'h4);
      tick();
      chk("pop_a", eif.aluA, 64'd8);
      loadInstr(4'h3, 4'h0, 64'h1234, 64'h0, 64'h999, 4'h7);
      tick();
      chk("irmov_a", eif.aluA, 64'h1234);
      chk("irmov_b", eif.aluB, 64'd0);

      // Downstream exceptions freeze the CC
      loadInstr(4'h6, 4'h0, 64'h0, 64'd1, 64'd1, 4'h1);
      tick();
      setFlags(1'b1, 1'b0, 1'b0);
      tick();
      eif.m_stat = 3'd3;
      setFlags(1'b0, 1'b1, 1'b0);
      tick();
      chk("frz_m_cc", 64'({eif.cc_zf, eif.cc_sf, eif.cc_of}), 64'b100);
      eif.m_stat = 3'd1;
      eif.W_stat = 3'd2;
      loadInstr(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
      tick();
      chk("frz_w_cc", 64'({eif.cc_zf, eif.cc_sf, eif.cc_of}), 64'b100);
      eif.W_stat = 3'd1;

      // Bubble, stall, stall+bubble, reset while stalled
      eif.E_bubble = 1'b1;
      loadInstr(4'h6, 4'h2, 64'h0, 64'h1, 64'h2, 4'h3);
      tick();
      chk("bub_icode", 64'(eif.E_icode), 64'd1);
      chk("bub_dstE",  64'(eif.e_dstE), 64'hF);
      eif.E_bubble = 1'b0;
      loadInstr(4'h6, 4'h3, 64'h0, 64'h11, 64'h22, 4'h3);
      tick();
      setFlags(1'b0, 1'b1, 1'b0);
      eif.E_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         loadInstr(4'($urandom_range(0, 11)), 4'($urandom), {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
         tick();
         chk("stall_valA",  eif.E_valA, 64'h11);
         chk("stall_icode", 64'(eif.E_icode), 64'd6);
      end
      eif.E_bubble = 1'b1;
      tick();
      chk("stbub_icode", 64'(eif.E_icode), 64'd6);
      rst = 1'b1;
      tick();
      chk("rstmid_icode", 64'(eif.E_icode), 64'd1);
      chk("rstmid_cc",    64'({eif.cc_zf, eif.cc_sf, eif.cc_of}), 64'b100);
      rst = 1'b0;
      eif.E_stall = 1'b0;
      eif.E_bubble = 1'b0;

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         eif.d_stat   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
         eif.d_icode  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 11));
         eif.d_ifun   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6));
         eif.d_valC   = {$urandom, $urandom};
         eif.d_valA   = {$urandom, $urandom};
         eif.d_valB   = {$urandom, $urandom};
         eif.d_dstE   = 4'($urandom);
         eif.d_dstM   = 4'($urandom);
         eif.d_srcA   = 4'($urandom);
         eif.d_srcB   = 4'($urandom);
         eif.m_stat   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
         eif.W_stat   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
         eif.E_stall  = ($urandom_range(0, 6) == 0);
         eif.E_bubble = ($urandom_range(0, 6) == 0);
         rst          = ($urandom_range(0, 49) == 0);
         setFlags(1'($urandom), 1'($urandom), 1'($urandom));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
